// File: rtl/ysyx_22041211_mem_resp.sv
// Data-memory responder: valid/ready request in, fixed-latency response out, byte-lane masked word array.
// Optional build macro MEM_ALIGN_CHK_EN turns misaligned accesses into error responses.
module ysyx_22041211_mem_resp #(
    parameter int unsigned DATA_LEN   = 32,
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned LATENCY    = 2,
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [31:0]         req_addr_i,
    input  logic                req_wen_i,
    input  logic [1:0]          req_size_i,
    input  logic [3:0]          req_wmask_i,
    input  logic [DATA_LEN-1:0] req_wdata_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [DATA_LEN-1:0] rsp_rdata_o,
    output logic                rsp_err_o
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [3:0]          r_cnt;
    logic                r_rsp_valid;
    logic [DATA_LEN-1:0] r_rdata;
    logic                r_err;

    logic [31:0]         r_addr;
    logic                r_wen;
    logic [1:0]          r_size;
    logic [3:0]          r_wmask;
    logic [DATA_LEN-1:0] r_wdata;

    logic [DATA_LEN-1:0] r_mem [0:(1<<DEPTH_LOG2)-1];

    logic                w_accept;
    logic                w_access;
    logic [31:0]         w_addr;
    logic                w_wen;
    logic [1:0]          w_size;
    logic [3:0]          w_wmask;
    logic [DATA_LEN-1:0] w_wdata;
    logic                w_in_range;
    logic                w_misalign;
    logic                w_err;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic [DATA_LEN-1:0] w_rd_word;

    // With LATENCY==1 the access happens on the accept edge, so use the live request.
    assign w_addr  = (r_state == S_IDLE) ? req_addr_i  : r_addr;
    assign w_wen   = (r_state == S_IDLE) ? req_wen_i   : r_wen;
    assign w_size  = (r_state == S_IDLE) ? req_size_i  : r_size;
    assign w_wmask = (r_state == S_IDLE) ? req_wmask_i : r_wmask;
    assign w_wdata = (r_state == S_IDLE) ? req_wdata_i : r_wdata;

    assign w_in_range = (w_addr >= BASE_ADDR) &&
                        ({1'b0, w_addr} < ({1'b0, BASE_ADDR} + (33'd4 << DEPTH_LOG2)));
    assign w_idx      = DEPTH_LOG2'((w_addr - BASE_ADDR) >> 2);
    assign w_rd_word  = r_mem[w_idx];

`ifdef MEM_ALIGN_CHK_EN
    assign w_misalign = ((w_size == 2'd1) && w_addr[0]) ||
                        (w_size[1] && (w_addr[1:0] != 2'b00));
`else
    logic w_unused_size;
    assign w_misalign    = 1'b0;
    assign w_unused_size = ^w_size;
`endif

    assign w_err = !w_in_range || w_misalign;

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_valid_i) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (LATENCY == 1) ? S_RESP : S_BUSY;
                end
            end
            S_BUSY: begin
                if (r_cnt == 4'd1) w_state_nxt = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready_i) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // The array access and response capture both happen on the RESP entry edge.
    assign w_access = (w_state_nxt == S_RESP) && (r_state != S_RESP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_rsp_valid <= 1'b0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_cnt <= 4'(LATENCY - 1);
            end else if (r_state == S_BUSY) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_access) begin
                r_rsp_valid <= 1'b1;
                r_err       <= w_err;
                r_rdata     <= (w_wen || w_err) ? '0 : (w_rd_word >> {w_addr[1:0], 3'b000});
            end else if ((r_state == S_RESP) && rsp_ready_i) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_addr  <= req_addr_i;
            r_wen   <= req_wen_i;
            r_size  <= req_size_i;
            r_wmask <= req_wmask_i;
            r_wdata <= req_wdata_i;
        end
        if (w_access && w_wen && !w_err) begin
            for (int i = 0; i < 4; i++) begin
                if (w_wmask[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
            end
        end
    end

    assign req_ready_o = (r_state == S_IDLE);
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_rdata_o = r_rdata;
    assign rsp_err_o   = r_err;

endmodule
